// File: rtl/fall_scheduler_if.sv
// Command/status bundle between the game-flow scheduler and the playfield datapath.
// master = scheduler side (drives strobes), slave = datapath/player side.
interface fall_scheduler_if #(
  parameter int ROWS = 20
);
  logic            tick_en;
  logic            speed_true;
  logic            game_start;
  logic            move_req;
  logic            move_dir;
  logic            move_ack;
  logic            collide_below;
  logic [ROWS-1:0] row_full;
  logic            spawn_blocked;
  logic            drop_pulse;
  logic            move_left;
  logic            move_right;
  logic            lock_pulse;
  logic            clear_pulse;
  logic [4:0]      clear_row;
  logic            spawn_pulse;
  logic            game_over;
  logic [2:0]      state;

  modport master (
    input  tick_en, speed_true, game_start, move_req, move_dir,
    input  collide_below, row_full, spawn_blocked,
    output move_ack, drop_pulse, move_left, move_right, lock_pulse,
    output clear_pulse, clear_row, spawn_pulse, game_over, state
  );

  modport slave (
    output tick_en, speed_true, game_start, move_req, move_dir,
    output collide_below, row_full, spawn_blocked,
    input  move_ack, drop_pulse, move_left, move_right, lock_pulse,
    input  clear_pulse, clear_row, spawn_pulse, game_over, state
  );
endinterface

// File: rtl/fall_scheduler.sv
// Game-flow controller: gravity timing, move arbitration, lock/clear/spawn/game-over sequencing.
// All strobes are registered one-cycle pulses (one cycle after the decision); moves wait behind drop/lock.
module fall_scheduler #(
  parameter int ROWS       = 20,
  parameter int SLOW_LIMIT = 10,
  parameter int FAST_LIMIT = 1,
  parameter int LOCK_TICKS = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clock_b,
  input  logic             resetn,
  fall_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    FALL  = 3'd2,
    LOCK  = 3'd3,
    CLEAR = 3'd4,
    WAIT  = 3'd5,
    OVER  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] SLOW_L   = CNT_W'(SLOW_LIMIT);
  localparam logic [CNT_W-1:0] FAST_L   = CNT_W'(FAST_LIMIT);
  localparam logic [CNT_W-1:0] LOCK_L   = CNT_W'(LOCK_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       LAST_IDX = 5'(ROWS - 1);

  state_t           cur_state;
  state_t           nxt_state;

  logic [CNT_W-1:0] grav_cnt;
  logic [CNT_W-1:0] grav_nxt;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_nxt;
  logic [CNT_W-1:0] lock_inc;
  logic [CNT_W-1:0] limit;
  logic [4:0]       scan_idx;
  logic [4:0]       scan_nxt;
  logic             spawned;
  logic             spawned_nxt;

  logic             drop_q,  drop_d;
  logic             left_q,  left_d;
  logic             right_q, right_d;
  logic             ack_q,   ack_d;
  logic             lock_q,  lock_d;
  logic             clear_q, clear_d;
  logic             spawn_q, spawn_d;
  logic             over_q;
  logic [4:0]       crow_q,  crow_d;

  logic             move_pend;
  logic             move_window;

  // A request stays high during its ack cycle, so the registered ack masks it.
  assign move_pend   = bus.move_req && !ack_q;
  assign move_window = (cur_state == FALL) || (cur_state == LOCK);
  assign lock_inc    = lock_cnt + CNT_ONE;

  always_comb begin
    nxt_state   = cur_state;
    grav_nxt    = grav_cnt;
    lock_nxt    = lock_cnt;
    scan_nxt    = scan_idx;
    spawned_nxt = spawned;
    crow_d      = crow_q;
    drop_d      = 1'b0;
    lock_d      = 1'b0;
    clear_d     = 1'b0;
    spawn_d     = 1'b0;
    left_d      = 1'b0;
    right_d     = 1'b0;
    ack_d       = 1'b0;
    limit       = bus.speed_true ? FAST_L : SLOW_L;

    case (cur_state)
      IDLE: begin
        if (bus.game_start) nxt_state = SPAWN;
      end

      SPAWN: begin
        if (!spawned) begin
          spawn_d     = 1'b1;
          spawned_nxt = 1'b1;
          grav_nxt    = '0;
          lock_nxt    = '0;
        end else if (!spawn_q) begin
          // Sample only after the load strobe has been absorbed by the datapath.
          spawned_nxt = 1'b0;
          nxt_state   = bus.spawn_blocked ? OVER : FALL;
        end
      end

      FALL: begin
        if (bus.tick_en) begin
          if (grav_cnt < limit) begin
            grav_nxt = grav_cnt + CNT_ONE;
          end else begin
            grav_nxt = '0;
            if (bus.collide_below) begin
              nxt_state = LOCK;
              lock_nxt  = '0;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
      end

      LOCK: begin
        if (!bus.collide_below) begin
          nxt_state = FALL;
          grav_nxt  = '0;
        end else if (bus.tick_en) begin
          lock_nxt = lock_inc;
          if (lock_inc >= LOCK_L) begin
            lock_d    = 1'b1;
            nxt_state = CLEAR;
            scan_nxt  = '0;
          end
        end
      end

      CLEAR: begin
        // Hold the first scan while the merge strobe is still on the wire.
        if (!lock_q) begin
          if (bus.row_full[scan_idx]) begin
            clear_d   = 1'b1;
            crow_d    = scan_idx;
            nxt_state = WAIT;
          end else if (scan_idx == LAST_IDX) begin
            nxt_state = SPAWN;
          end else begin
            scan_nxt = scan_idx + 5'd1;
          end
        end
      end

      WAIT: begin
        nxt_state = CLEAR;
      end

      OVER: begin
        if (bus.game_start) nxt_state = SPAWN;
      end

      default: begin
        nxt_state = IDLE;
      end
    endcase

    if (move_window && move_pend && !drop_d && !lock_d) begin
      left_d  = !bus.move_dir;
      right_d = bus.move_dir;
      ack_d   = 1'b1;
    end
  end

  always_ff @(posedge clock_b or negedge resetn) begin
    if (!resetn) begin
      cur_state <= IDLE;
      grav_cnt  <= '0;
      lock_cnt  <= '0;
      scan_idx  <= '0;
      spawned   <= 1'b0;
      drop_q    <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      ack_q     <= 1'b0;
      lock_q    <= 1'b0;
      clear_q   <= 1'b0;
      spawn_q   <= 1'b0;
      over_q    <= 1'b0;
      crow_q    <= '0;
    end else begin
      cur_state <= nxt_state;
      grav_cnt  <= grav_nxt;
      lock_cnt  <= lock_nxt;
      scan_idx  <= scan_nxt;
      spawned   <= spawned_nxt;
      drop_q    <= drop_d;
      left_q    <= left_d;
      right_q   <= right_d;
      ack_q     <= ack_d;
      lock_q    <= lock_d;
      clear_q   <= clear_d;
      spawn_q   <= spawn_d;
      over_q    <= (nxt_state == OVER);
      crow_q    <= crow_d;
    end
  end

  assign bus.drop_pulse  = drop_q;
  assign bus.move_left   = left_q;
  assign bus.move_right  = right_q;
  assign bus.move_ack    = ack_q;
  assign bus.lock_pulse  = lock_q;
  assign bus.clear_pulse = clear_q;
  assign bus.clear_row   = crow_q;
  assign bus.spawn_pulse = spawn_q;
  assign bus.game_over   = over_q;
  assign bus.state       = cur_state;

endmodule

// File: tb/tb_fall_scheduler.sv
// Directed bench for fall_scheduler: start/over table, then gravity, soft drop, arbitration, lock, clear, reset sequences.
module tb_fall_scheduler;

  logic clock_b = 1'b0;
  logic resetn;

  always #5 clock_b = ~clock_b;

  fall_scheduler_if #(.ROWS(20)) bus ();

  fall_scheduler #(
    .ROWS(20), .SLOW_LIMIT(10), .FAST_LIMIT(1), .LOCK_TICKS(2), .CNT_W(4)
  ) dut (
    .clock_b (clock_b),
    .resetn  (resetn),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int n_drop = 0, n_ack = 0, n_lock = 0, n_spawn = 0, n_clear = 0;

  typedef struct packed {
    logic       rst_n;
    logic       gs;
    logic       blk;
    logic [2:0] st;
    logic       sp;
    logic       go;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] del_row(input logic [19:0] f, input int r);
    logic [19:0] lo;
    lo = (20'd1 << r) - 20'd1;
    return (f & lo) | ((f >> 1) & ~lo);
  endfunction

  // One clock; outputs sampled 1 time unit after the edge; datapath row-delete model applied.
  task automatic step();
    @(posedge clock_b);
    #1;
    if (bus.drop_pulse)  n_drop++;
    if (bus.move_ack)    n_ack++;
    if (bus.lock_pulse)  n_lock++;
    if (bus.spawn_pulse) n_spawn++;
    if (bus.clear_pulse) begin
      n_clear++;
      bus.row_full = del_row(bus.row_full, int'(bus.clear_row));
    end
  endtask

  task automatic wait_drop(input int max, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.drop_pulse && cyc <= max);
  endtask

  task automatic wait_state(input logic [2:0] target, input int max, input string name);
    int c = 0;
    while (bus.state !== target && c < max) begin
      step();
      c++;
    end
    chk(name, bus.state, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    int base;
    int c;

    resetn            = 1'b0;
    bus.tick_en       = 1'b0;
    bus.speed_true    = 1'b0;
    bus.game_start    = 1'b0;
    bus.move_req      = 1'b0;
    bus.move_dir      = 1'b0;
    bus.collide_below = 1'b0;
    bus.row_full      = '0;
    bus.spawn_blocked = 1'b0;

    //         rst  gs   blk  state sp   go
    vt[0]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0};

    #2;
    chk("reset_state", bus.state, 3'd0);
    chk("reset_strobes", {bus.drop_pulse, bus.move_left, bus.move_right, bus.lock_pulse,
                          bus.clear_pulse, bus.spawn_pulse, bus.move_ack, bus.game_over}, 8'h00);

    for (int i = 0; i < 12; i++) begin
      resetn            = vt[i].rst_n;
      bus.game_start    = vt[i].gs;
      bus.spawn_blocked = vt[i].blk;
      step();
      chk($sformatf("vec%0d_state", i), bus.state, vt[i].st);
      chk($sformatf("vec%0d_spawn", i), bus.spawn_pulse, vt[i].sp);
      chk($sformatf("vec%0d_over", i), bus.game_over, vt[i].go);
    end
    bus.game_start = 1'b0;

    // Gravity at slow rate: 11 ticks per row.
    bus.tick_en = 1'b1;
    wait_drop(20, g); chk("slow_first_gap", g, 11);
    wait_drop(20, g); chk("slow_gap", g, 11);

    // Soft drop engaged with cnt=5: due on the next tick, then every 2.
    base = n_drop;
    for (int i = 0; i < 5; i++) step();
    chk("no_drop_before_fast", n_drop - base, 0);
    bus.speed_true = 1'b1;
    wait_drop(20, g); chk("fast_first_gap", g, 1);
    wait_drop(20, g); chk("fast_gap_a", g, 2);
    wait_drop(20, g); chk("fast_gap_b", g, 2);
    bus.speed_true = 1'b0;
    wait_drop(20, g); chk("release_gap", g, 11);

    // Move request arriving with a due drop: drop first, move one cycle later.
    for (int i = 0; i < 10; i++) step();
    base = n_ack;
    bus.move_req = 1'b1;
    bus.move_dir = 1'b1;
    step();
    chk("arb_drop", bus.drop_pulse, 1'b1);
    chk("arb_right_deferred", bus.move_right, 1'b0);
    chk("arb_ack_deferred", bus.move_ack, 1'b0);
    step();
    chk("arb_right", bus.move_right, 1'b1);
    chk("arb_left_quiet", bus.move_left, 1'b0);
    chk("arb_ack", bus.move_ack, 1'b1);
    step();
    chk("arb_no_reack", bus.move_ack, 1'b0);
    bus.move_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("arb_one_ack", n_ack - base, 1);

    bus.move_req = 1'b1;
    bus.move_dir = 1'b0;
    step();
    chk("move_left", bus.move_left, 1'b1);
    chk("move_left_not_right", bus.move_right, 1'b0);
    step();
    bus.move_req = 1'b0;

    // Resting piece, support removed after one tick: back to FALL without locking.
    base = n_drop;
    bus.collide_below = 1'b1;
    wait_state(3'd3, 15, "enter_lock");
    chk("lock_no_drop", n_drop - base, 0);
    step();
    chk("lock_tick1_state", bus.state, 3'd3);
    chk("lock_tick1_pulse", bus.lock_pulse, 1'b0);
    bus.collide_below = 1'b0;
    step();
    chk("release_to_fall", bus.state, 3'd2);

    base = n_lock;
    bus.collide_below = 1'b1;
    wait_state(3'd3, 15, "enter_lock_again");
    chk("no_lock_after_release", n_lock - base, 0);
    bus.row_full = 20'h00003;
    step();
    chk("lock_wait_pulse", bus.lock_pulse, 1'b0);
    step();
    chk("lock_pulse", bus.lock_pulse, 1'b1);
    chk("lock_to_clear", bus.state, 3'd4);
    bus.collide_below = 1'b0;

    // Rows 0 and 1 full: row 0 cleared twice after the shift, then spawn.
    base = n_clear;
    c = 0;
    while (!bus.spawn_pulse && c < 60) begin
      step();
      c++;
      if (bus.clear_pulse) chk("clear_row_idx", bus.clear_row, 5'd0);
    end
    chk("clear_count", n_clear - base, 2);
    chk("clear_then_spawn", bus.spawn_pulse, 1'b1);
    chk("field_cleared", bus.row_full, 20'h0);
    wait_state(3'd2, 5, "respawn_fall");

    // Reset asserted mid-CLEAR while a clear strobe is on the wire.
    bus.row_full      = 20'h00004;
    bus.collide_below = 1'b1;
    wait_state(3'd4, 30, "reach_clear");
    c = 0;
    while (!bus.clear_pulse && c < 10) begin
      step();
      c++;
    end
    chk("clear_row2_pulse", bus.clear_pulse, 1'b1);
    chk("clear_row2_idx", bus.clear_row, 5'd2);
    resetn = 1'b0;
    #2;
    chk("arst_state", bus.state, 3'd0);
    chk("arst_clear_pulse", bus.clear_pulse, 1'b0);
    chk("arst_clear_row", bus.clear_row, 5'd0);
    chk("arst_strobes", {bus.drop_pulse, bus.move_left, bus.move_right, bus.lock_pulse,
                         bus.spawn_pulse, bus.move_ack, bus.game_over}, 7'h00);
    step();
    resetn = 1'b1;
    bus.collide_below = 1'b0;
    step();
    chk("post_reset_idle", bus.state, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fall_scheduler.md
Name: fall_scheduler

Overview:
- Game-flow controller for the 20x20 playfield datapath (400-bit field, row r = bits [20r+19:20r]).
- Owns gravity timing (slow/fast), arbitrates gravity drops against player move requests, and sequences piece lock, row-clear scan, spawn and game-over.
- Issues one-cycle command strobes to the field datapath and reads back collision and row-full status.

Parameters:
- ROWS, 20, number of playfield rows; width of row_full.
- SLOW_LIMIT, 10, tick count limit for normal gravity.
- FAST_LIMIT, 1, tick count limit while soft drop is held.
- LOCK_TICKS, 2, ticks a resting piece waits before locking.
- CNT_W, 4, width of gravity and lock counters.

Ports:
- clock_b  in  1  system clock; all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- tick_en  in  1  one-cycle game-tick enable.
- speed_true  in  1  soft drop held (selects FAST_LIMIT).
- game_start  in  1  start request pulse.
- move_req  in  1  player move request (level, handshake).
- move_dir  in  1  0 = left, 1 = right; stable while move_req is high.
- move_ack  out  1  one-cycle acknowledge.
- collide_below  in  1  datapath: active piece cannot descend.
- row_full  in  ROWS  datapath: per-row full flags.
- spawn_blocked  in  1  datapath: new piece overlaps the stack.
- drop_pulse  out  1  shift active piece down one row.
- move_left  out  1  shift active piece left one column.
- move_right  out  1  shift active piece right one column.
- lock_pulse  out  1  merge active piece into the stack.
- clear_pulse  out  1  delete row clear_row and shift the rows above down.
- clear_row  out  5  row index for clear_pulse.
- spawn_pulse  out  1  load a new piece at the top.
- game_over  out  1  level high in OVER.
- state  out  3  current state encoding: IDLE=0, SPAWN=1, FALL=2, LOCK=3, CLEAR=4, WAIT=5, OVER=6.

Behaviour:
- Reset (async, while resetn=0): state=IDLE; all strobes, move_ack and game_over are 0; clear_row=0; gravity, lock and scan counters are 0.
- All strobe outputs are registered and high for exactly one cycle.
- IDLE: game_start -> SPAWN. Everything else is ignored.
- SPAWN: assert spawn_pulse for 1 cycle; clear the gravity and lock counters.
  - Next cycle, sample spawn_blocked: 1 -> OVER, 0 -> FALL.
- Gravity counter (FALL only), evaluated on tick_en:
  - limit = speed_true ? FAST_LIMIT : SLOW_LIMIT, sampled on that tick.
  - If cnt < limit: cnt+1.
  - Else: cnt=0 and a drop is due.
  - Switching to fast with cnt above the limit makes the drop due on the next tick.
- FALL, drop due:
  - collide_below=0: drop_pulse.
  - collide_below=1: no drop; go to LOCK with lock_cnt=0.
- LOCK:
  - Each tick_en increments lock_cnt.
  - If collide_below falls to 0 before the lock completes: return to FALL, gravity cnt=0.
  - When lock_cnt reaches LOCK_TICKS: lock_pulse, go to CLEAR with scan index=0.
- Move arbitration (FALL and LOCK only):
  - A pending move_req issues move_left or move_right (per move_dir) together with move_ack in the same cycle.
  - If a drop or lock strobe fires in that cycle, the drop or lock wins and the move is deferred one cycle.
  - In LOCK, a move deferred behind lock_pulse is dropped and not acked; requester keeps move_req high.
  - Requester deasserts move_req the cycle after move_ack; one ack per request.
  - In other states move_req is held pending with move_ack=0.
- CLEAR scans one row index per cycle, from 0 to ROWS-1:
  - row_full[idx]=1: clear_pulse with clear_row=idx, go to WAIT for 1 cycle so the datapath updates, then re-check the same idx.
  - row_full[idx]=0 and idx=ROWS-1: go to SPAWN.
  - Otherwise: idx+1.
- OVER: game_over=1; game_start -> SPAWN, and game_over deasserts in the cycle after game_start is sampled.
- game_start in SPAWN, FALL, LOCK, CLEAR or WAIT is ignored.
- Reset asserted mid-operation forces IDLE immediately; no pending strobe completes.

Test Plan:
- Gravity: reset, game_start, spawn_blocked=0, tick_en every cycle, speed_true=0, collide_below=0 -> spawn_pulse once, then drop_pulse every 11 ticks.
- Soft drop: cnt=5, then speed_true=1 -> drop_pulse on the next tick, then every 2 ticks; release speed_true -> 11-tick period.
- Arbitration: move_req=1, move_dir=1 in the same cycle a drop is due -> drop_pulse that cycle; move_right and move_ack the next cycle; exactly one ack.
- Lock: collide_below=1 at the drop -> LOCK; lock_pulse after 2 more ticks. Repeat with collide_below dropped after 1 tick -> return to FALL, no lock_pulse.
- Clear: row_full=0x00003 after lock, datapath clears row 0 and shifts -> clear_pulse with clear_row=0 twice (re-check), no further clears, then spawn_pulse.
- Game over: spawn_blocked=1 at spawn -> game_over=1, state=6; game_start -> spawn_pulse. Separately, resetn=0 mid-CLEAR -> state=0 and all outputs 0 asynchronously.
